// File: rtl/apb_controller.sv
// Purpose : bridge-side APB master FSM; turns decoded AHB requests into APB SETUP/ACCESS pairs.
// Latency : read = SETUP, ACCESS (1 stall cycle); write = WWAIT, SETUP, ACCESS (2 stall cycles).
// Backpres: hready_out is low in WWAIT/SETUP; new requests are accepted only in IDLE or ACCESS.
//
// Ports:
//   hclk, hresetn            clock (rising edge), asynchronous active-low reset
//   valid, haddr, hwrite,    AHB address phase of a request aimed at an APB slave
//   tempselx                 one-hot slave select from the address decoder
//   hwdata                   AHB write data, stable for the whole write data phase
//   prdata                   read data returned by the APB interface stage
//   pwrite, penable, psel,   APB master signals, all driven from state/latch registers
//   paddr, pwdata
//   hready_out, hrdata       AHB data-phase completion and read data
module apb_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [SEL_WIDTH-1:0]  tempselx,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  pwrite,
  output logic                  penable,
  output logic [SEL_WIDTH-1:0]  psel,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic                  hready_out,
  output logic [DATA_WIDTH-1:0] hrdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WWAIT  = 2'd1,
    SETUP  = 2'd2,
    ACCESS = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic                   write_q;
  logic [DATA_WIDTH-1:0]  wdata_q;

  // Request capture strobe: a new AHB address phase is only consumed while
  // hready_out is high, i.e. in IDLE or in the closing ACCESS cycle.
  logic                   take_req;
  // Write data capture strobe: the AHB data phase of a write is in progress
  // during WWAIT, and the master holds hwdata stable because we stall it.
  logic                   take_wdata;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    take_req   = 1'b0;
    take_wdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          take_req = 1'b1;
          state_d  = hwrite ? WWAIT : SETUP;
        end
      end
      WWAIT: begin
        take_wdata = 1'b1;
        state_d    = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // Chaining straight into the next transfer avoids an IDLE bubble.
        if (valid) begin
          take_req = 1'b1;
          state_d  = hwrite ? WWAIT : SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q  <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
    end else if (take_req) begin
      addr_q  <= haddr;
      sel_q   <= tempselx;
      write_q <= hwrite;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wdata_q <= '0;
    end else if (take_wdata) begin
      wdata_q <= hwdata;
    end
  end

  // APB side: everything comes from flops, so no decode glitches reach the
  // slaves. The latches only change on the edge that leaves IDLE/ACCESS/WWAIT,
  // so paddr/pwrite/pwdata are stable across each SETUP+ACCESS pair.
  logic in_xfer;
  assign in_xfer = (state_q == SETUP) || (state_q == ACCESS);

  assign psel    = in_xfer ? sel_q : '0;
  assign penable = (state_q == ACCESS);
  assign pwrite  = write_q;
  assign paddr   = addr_q;
  assign pwdata  = wdata_q;

  // AHB side: the data phase finishes in IDLE (nothing pending) or ACCESS.
  assign hready_out = (state_q == IDLE) || (state_q == ACCESS);

  // Read data is a straight pass-through during a read ACCESS so the master
  // captures it on the same edge that closes the APB transfer.
  assign hrdata = ((state_q == ACCESS) && !write_q) ? prdata : '0;

endmodule

// File: tb/tb_apb_controller.sv
// Purpose : directed vector bench for apb_controller.
// Latency : inputs applied at falling edge, outputs sampled 1 time unit later.
// Backpres: stall cycles are part of the expected-value tables.
module tb_apb_controller;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 3;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          valid = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic          hwrite = 1'b0;
  logic [SW-1:0] tempselx = '0;
  logic [DW-1:0] hwdata = '0;
  logic [DW-1:0] prdata = '0;
  logic          pwrite;
  logic          penable;
  logic [SW-1:0] psel;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          hready_out;
  logic [DW-1:0] hrdata;

  int checks = 0;
  int passes = 0;

  always #5 hclk = ~hclk;

  apb_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .valid      (valid),
    .haddr      (haddr),
    .hwrite     (hwrite),
    .tempselx   (tempselx),
    .hwdata     (hwdata),
    .prdata     (prdata),
    .pwrite     (pwrite),
    .penable    (penable),
    .psel       (psel),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .hready_out (hready_out),
    .hrdata     (hrdata)
  );

  typedef struct {
    logic          v;
    logic          w;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          apb_chk;  // compare paddr/pwrite/pwdata only when the APB phase is live
    logic [SW-1:0] e_psel;
    logic          e_pen;
    logic          e_pwr;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata;
    logic          e_rdy;
    logic [DW-1:0] e_hrdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic v, input logic w, input logic [AW-1:0] a, input logic [SW-1:0] s,
    input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic apb_chk,
    input logic [SW-1:0] e_psel, input logic e_pen, input logic e_pwr,
    input logic [AW-1:0] e_paddr, input logic [DW-1:0] e_pwdata,
    input logic e_rdy, input logic [DW-1:0] e_hrdata);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.s = s; t.wd = wd; t.rd = rd; t.apb_chk = apb_chk;
    t.e_psel = e_psel; t.e_pen = e_pen; t.e_pwr = e_pwr; t.e_paddr = e_paddr;
    t.e_pwdata = e_pwdata; t.e_rdy = e_rdy; t.e_hrdata = e_hrdata;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [SW-1:0] s, input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    valid = v; hwrite = w; haddr = a; tempselx = s; hwdata = wd; prdata = rd;
  endtask

  initial begin
    // Columns: valid hwrite haddr sel hwdata prdata | apb_chk psel pen pwrite paddr pwdata hready hrdata
    // Single write 0x8000_0010 sel 001, haddr/hwrite toggled during the stall.
    vecs.push_back(mk(1, 1, 32'h8000_0010, 3'b001, 32'h0,         32'h0,  0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h0));
    vecs.push_back(mk(1, 1, 32'h8000_0010, 3'b001, 32'hA5A5_1234, 32'h0,  0, 3'b000, 0, 0, 32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 0, 32'hDEAD_BEEF, 3'b111, 32'h0,         32'h0,  1, 3'b001, 0, 1, 32'h8000_0010, 32'hA5A5_1234, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         3'b000, 32'h0,         32'h77, 1, 3'b001, 1, 1, 32'h8000_0010, 32'hA5A5_1234, 1, 32'h0));
    // Single read 0x8400_0004 sel 010, then IDLE.
    vecs.push_back(mk(1, 0, 32'h8400_0004, 3'b010, 32'h0,         32'h33, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h0));
    vecs.push_back(mk(0, 1, 32'hFFFF_0000, 3'b000, 32'h0,         32'h44, 1, 3'b010, 0, 0, 32'h8400_0004, 32'hA5A5_1234, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         3'b000, 32'h0,         32'hC8, 1, 3'b010, 1, 0, 32'h8400_0004, 32'hA5A5_1234, 1, 32'hC8));
    // Back-to-back reads 0x8000_0000 / 0x8000_0004, then write 0x8000_0020 chained from ACCESS.
    vecs.push_back(mk(1, 0, 32'h8000_0000, 3'b001, 32'h0,         32'h11, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h8000_0000, 3'b001, 32'h0,         32'h22, 1, 3'b001, 0, 0, 32'h8000_0000, 32'hA5A5_1234, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h8000_0004, 3'b001, 32'h0,         32'h5A, 1, 3'b001, 1, 0, 32'h8000_0000, 32'hA5A5_1234, 1, 32'h5A));
    vecs.push_back(mk(1, 0, 32'h8000_0004, 3'b001, 32'h0,         32'h66, 1, 3'b001, 0, 0, 32'h8000_0004, 32'hA5A5_1234, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h8000_0020, 3'b010, 32'h0,         32'hFF, 1, 3'b001, 1, 0, 32'h8000_0004, 32'hA5A5_1234, 1, 32'hFF));
    vecs.push_back(mk(1, 1, 32'h8000_0020, 3'b010, 32'h1234_5678, 32'h0,  0, 3'b000, 0, 0, 32'h0,         32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h8000_0020, 3'b010, 32'h1234_5678, 32'h0,  1, 3'b010, 0, 1, 32'h8000_0020, 32'h1234_5678, 0, 32'h0));
    // Write ACCESS with a chained read 0x8800_0008 sel 100.
    vecs.push_back(mk(1, 0, 32'h8800_0008, 3'b100, 32'h0,         32'h99, 1, 3'b010, 1, 1, 32'h8000_0020, 32'h1234_5678, 1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h8800_0008, 3'b100, 32'h0,         32'h10, 1, 3'b100, 0, 0, 32'h8800_0008, 32'h1234_5678, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         3'b000, 32'h0,         32'hAB, 1, 3'b100, 1, 0, 32'h8800_0008, 32'h1234_5678, 1, 32'hAB));
    // Read with tempselx = 0 still runs SETUP+ACCESS, psel stays 0.
    vecs.push_back(mk(1, 0, 32'h8C00_000C, 3'b000, 32'h0,         32'h0,  0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         3'b000, 32'h0,         32'h3C, 1, 3'b000, 0, 0, 32'h8C00_000C, 32'h1234_5678, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         3'b000, 32'h0,         32'h3C, 1, 3'b000, 1, 0, 32'h8C00_000C, 32'h1234_5678, 1, 32'h3C));
    vecs.push_back(mk(0, 0, 32'h0,         3'b000, 32'h0,         32'h3C, 0, 3'b000, 0, 0, 32'h0,         32'h0,         1, 32'h0));

    // Reset state.
    #2;
    chk("rst_psel",   32'(psel),       32'h0);
    chk("rst_pen",    32'(penable),    32'h0);
    chk("rst_pwrite", 32'(pwrite),     32'h0);
    chk("rst_paddr",  paddr,           32'h0);
    chk("rst_pwdata", pwdata,          32'h0);
    chk("rst_hready", 32'(hready_out), 32'h1);
    chk("rst_hrdata", hrdata,          32'h0);
    @(negedge hclk);
    hresetn = 1'b1;

    // Table-driven cycles.
    foreach (vecs[i]) begin
      @(negedge hclk);
      drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].wd, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_psel", i),   32'(psel),       32'(vecs[i].e_psel));
      chk($sformatf("v%0d_pen", i),    32'(penable),    32'(vecs[i].e_pen));
      chk($sformatf("v%0d_hready", i), 32'(hready_out), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_hrdata", i), hrdata,          vecs[i].e_hrdata);
      if (vecs[i].apb_chk) begin
        chk($sformatf("v%0d_pwrite", i), 32'(pwrite), 32'(vecs[i].e_pwr));
        chk($sformatf("v%0d_paddr", i),  paddr,       vecs[i].e_paddr);
        chk($sformatf("v%0d_pwdata", i), pwdata,      vecs[i].e_pwdata);
      end
    end

    // Reset asserted during the ACCESS cycle of a write.
    @(negedge hclk);
    drive(1, 1, 32'h9000_0000, 3'b001, 32'h0, 32'h0);   // IDLE: request taken
    @(negedge hclk);
    drive(1, 1, 32'h9000_0000, 3'b001, 32'hCAFE_F00D, 32'h0);  // WWAIT
    @(negedge hclk);                                     // SETUP
    @(negedge hclk);                                     // ACCESS
    drive(0, 0, 32'h0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("mid_pen_before_rst", 32'(penable), 32'h1);
    chk("mid_paddr_before_rst", paddr, 32'h9000_0000);
    hresetn = 1'b0;
    #1;
    chk("mid_rst_psel",   32'(psel),       32'h0);
    chk("mid_rst_pen",    32'(penable),    32'h0);
    chk("mid_rst_hready", 32'(hready_out), 32'h1);
    chk("mid_rst_paddr",  paddr,           32'h0);
    chk("mid_rst_pwdata", pwdata,          32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      #1;
      chk($sformatf("post_rst%0d_psel", k),   32'(psel),       32'h0);
      chk($sformatf("post_rst%0d_pen", k),    32'(penable),    32'h0);
      chk($sformatf("post_rst%0d_hready", k), 32'(hready_out), 32'h1);
    end

    // Read after reset: ACCESS must arrive exactly two edges after the request.
    begin
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      @(negedge hclk);
      drive(1, 0, 32'h8000_0100, 3'b100, 32'h0, 32'h0000_00E7);
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge hclk);
        valid = 1'b0;
        n++;
        #1;
        if (penable === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
        chk("read_access_timeout", 32'h0, 32'h1);
      end else begin
        chk("read_latency",  32'(n),    32'h2);
        chk("read_hrdata",   hrdata,    32'h0000_00E7);
        chk("read_psel",     32'(psel), 32'h4);
        chk("read_paddr",    paddr,     32'h8000_0100);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
